// File: rtl/add32_byte_serial_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the byte-serial adder.
package add_pkg;

    localparam int BYTE_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Byte-counter width: clog2(nbytes), never narrower than one bit.
    function automatic int cnt_width(input int nbytes);
        return (nbytes <= 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/add8.sv
// 8-bit adder with carry in/out, signed overflow and overflow-corrected sign.
module add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       carry_out,
    output logic       sign,
    output logic       overflow
);

    logic [8:0] w_full;

    assign w_full    = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
    assign sum       = w_full[7:0];
    assign carry_out = w_full[8];
    assign overflow  = (a[7] == b[7]) && (w_full[7] != a[7]);
    assign sign      = w_full[7] ^ overflow;

endmodule

// File: rtl/add32_byte_serial.sv
// Multi-cycle WIDTH-bit adder: one add8 processes a byte per cycle, LSB first,
// with the carry registered between bytes and valid/ready handshakes on both sides.
module add32_byte_serial
    import add_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             sign,
    output logic             overflow
);

    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int IDX_W  = cnt_width(NBYTES);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_psum;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_sign;
    logic               r_ovf;

    logic [BYTE_W-1:0]  w_sum8;
    logic               w_cout8;
    logic               w_sign8;
    logic               w_ovf8;
    logic               w_last;
    logic [WIDTH-1:0]   w_psum_next;

    add8 u_add8 (
        .a         (r_a[BYTE_W-1:0]),
        .b         (r_b[BYTE_W-1:0]),
        .carry_in  (r_carry),
        .sum       (w_sum8),
        .carry_out (w_cout8),
        .sign      (w_sign8),
        .overflow  (w_ovf8)
    );

    assign w_last = (r_state == RUN) && (r_idx == IDX_W'(NBYTES - 1));

    // Result bytes enter at the top so after NBYTES steps byte 0 sits at the LSB.
    assign w_psum_next = (r_psum >> BYTE_W) | (WIDTH'(w_sum8) << (WIDTH - BYTE_W));

    assign in_ready  = (r_state == IDLE) && !reset;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign sign      = r_sign;
    assign overflow  = r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_psum      <= '0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_sign      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= carry_in;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> BYTE_W;
                    r_b     <= r_b >> BYTE_W;
                    r_psum  <= w_psum_next;
                    r_carry <= w_cout8;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_sum       <= w_psum_next;
                        r_cout      <= w_cout8;
                        r_sign      <= w_sign8;
                        r_ovf       <= w_ovf8;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add32_byte_serial.sv
// Directed plus randomized bench for add32_byte_serial against an arithmetic reference model.
module tb_add32_byte_serial;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        carry_out;
    logic        sign;
    logic        overflow;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] e_sum;
    logic        e_cout;
    logic        e_sign;
    logic        e_ovf;

    always #5 clk = ~clk;

    add32_byte_serial #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .sign      (sign),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain 33-bit arithmetic; sign is the sign of the unbounded signed result.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mc);
        logic [32:0] full;
        full   = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
        e_sum  = full[31:0];
        e_cout = full[32];
        e_ovf  = (ma[31] == mb[31]) && (full[31] != ma[31]);
        e_sign = e_ovf ? ma[31] : full[31];
    endtask

    task automatic check_result(input string tag);
        check({tag, ".sum"},  sum,               e_sum);
        check({tag, ".cout"}, {31'd0, carry_out}, {31'd0, e_cout});
        check({tag, ".ovf"},  {31'd0, overflow},  {31'd0, e_ovf});
        check({tag, ".sign"}, {31'd0, sign},      {31'd0, e_sign});
    endtask

    // Called away from an edge; returns at a negedge with out_valid expected high.
    task automatic start_and_wait(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                                  input string tag);
        int lat;
        int w;
        a        = ta;
        b        = tb_;
        carry_in = tc;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        carry_in = 1'($urandom);
        model(ta, tb_, tc);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        check({tag, ".latency"}, lat, 32'd4);
        check_result(tag);
    endtask

    task automatic hold_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, ".hold_ready"}, {31'd0, in_ready},  32'd0);
            check_result({tag, ".hold"});
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, ".rel_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".rel_ready"}, {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;

        // 1. Reset for two cycles
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst.out_valid", {31'd0, out_valid}, 32'd0);
            check("rst.in_ready",  {31'd0, in_ready},  32'd0);
            check("rst.sum",       sum,                32'd0);
            check("rst.flags",     {29'd0, carry_out, sign, overflow}, 32'd0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1 check("rel.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // 2-4. Directed arithmetic cases
        start_and_wait(32'h000000FF, 32'h00000001, 1'b0, "byte_carry");
        release_result("byte_carry");
        start_and_wait(32'hFFFFFFFF, 32'h00000000, 1'b1, "ripple");
        release_result("ripple");
        start_and_wait(32'h7FFFFFFF, 32'h00000001, 1'b0, "ovf_pos");
        check("ovf_pos.const", sum, 32'h80000000);
        release_result("ovf_pos");
        start_and_wait(32'h80000000, 32'h80000000, 1'b0, "ovf_neg");
        check("ovf_neg.sign", {31'd0, sign}, 32'd1);
        release_result("ovf_neg");
        start_and_wait(32'h7FFFFFFF, 32'h00000000, 1'b1, "ovf_cin");
        check("ovf_cin.ovf", {31'd0, overflow}, 32'd1);
        release_result("ovf_cin");

        // 5. Backpressure with new operands pending
        start_and_wait(32'hDEADBEEF, 32'h01234567, 1'b1, "bp");
        a        = 32'h0F0F0F0F;
        b        = 32'hF0F0F0F1;
        carry_in = 1'b0;
        in_valid = 1'b1;
        hold_cycles(3, "bp");
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp.rel_valid", {31'd0, out_valid}, 32'd0);
        check("bp.rel_ready", {31'd0, in_ready},  32'd1);
        start_and_wait(32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, "bp_next");
        release_result("bp_next");

        // 6. Reset while idx==2
        a        = 32'hAAAA5555;
        b        = 32'h12121212;
        carry_in = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst.sum",       sum,                32'd0);
        check("midrst.flags",     {29'd0, carry_out, sign, overflow}, 32'd0);
        check("midrst.in_ready",  {31'd0, in_ready},  32'd1);
        repeat (6) begin
            @(negedge clk);
            check("midrst.no_result", {31'd0, out_valid}, 32'd0);
        end
        start_and_wait(32'h12345678, 32'h11111111, 1'b0, "post_rst");
        check("post_rst.const", sum, 32'h23456789);
        release_result("post_rst");

        // Randomized operations with random consumer stalls
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom);
            if (i % 6 == 0) rb = ~ra;
            start_and_wait(ra, rb, rc, "rand");
            hold_cycles(int'($urandom_range(0, 3)), "rand");
            release_result("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
